// File: rtl/ysyx_22040632_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_22040632_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // Instruction fetches are always 4-byte reads.
    localparam logic [1:0] IF_FETCH_SIZE = 2'd2;

endpackage

// File: rtl/ysyx_22040632_arb_pick.sv
// Combinational winner selection between IFU and LSU requests.
// YSYX_22040632_ARB_RR_EN selects round robin; otherwise LSU has fixed priority.
module ysyx_22040632_arb_pick
    import ysyx_22040632_pkg::*;
(
    input  logic       if_valid,
    input  logic       if_flush,
    input  logic       ls_valid,
    input  arb_owner_t last_owner,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    logic if_eligible;

    assign if_eligible = if_valid && !if_flush;
    assign grant_valid = if_eligible || ls_valid;

`ifdef YSYX_22040632_ARB_RR_EN
    always_comb begin
        grant_owner = OWN_IF;
        if (if_eligible && ls_valid)
            grant_owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
        else if (ls_valid)
            grant_owner = OWN_LS;
    end
`else
    logic unused_last_owner;

    assign unused_last_owner = last_owner;

    always_comb begin
        grant_owner = OWN_IF;
        if (ls_valid)
            grant_owner = OWN_LS;
    end
`endif

endmodule

// File: rtl/ysyx_22040632_mem_arbiter.sv
// Shares the core memory bus between IFU fetches and LSU loads/stores, one transaction at a time.
// Arbitration policy is set by YSYX_22040632_ARB_RR_EN (see ysyx_22040632_arb_pick).
module ysyx_22040632_mem_arbiter
    import ysyx_22040632_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_resp_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    input  logic [1:0]          ls_size,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [1:0]          mem_size,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, last_owner_q;
    logic       drop_q;
    logic       grant_valid;
    arb_owner_t grant_owner;
    logic       resp_fire;

    ysyx_22040632_arb_pick u_pick (
        .if_valid    (if_req_valid),
        .if_flush    (if_flush),
        .ls_valid    (ls_req_valid),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign resp_fire = (state_q == ARB_RESP) && mem_resp_valid;

    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    if_req_ready = (grant_owner == OWN_IF);
                    ls_req_ready = (grant_owner == OWN_LS);
                    state_d      = ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (mem_resp_valid) begin
                    if_resp_valid = (owner_q == OWN_IF) && !drop_q;
                    ls_resp_valid = (owner_q == OWN_LS);
                    state_d       = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign if_rdata    = mem_rdata;
    assign ls_rdata    = mem_rdata;
    assign if_resp_err = mem_resp_err;
    assign ls_resp_err = mem_resp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            drop_q       <= 1'b0;
            mem_addr     <= '0;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            mem_size     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && grant_valid) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_LS) begin
                    mem_addr  <= ls_addr;
                    mem_wen   <= ls_wen;
                    mem_wdata <= ls_wdata;
                    mem_wstrb <= ls_wstrb;
                    mem_size  <= ls_size;
                end else begin
                    mem_addr  <= if_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                    mem_size  <= IF_FETCH_SIZE;
                end
            end
            // Completion clears drop even if a flush arrives in the same cycle.
            if (resp_fire) begin
                drop_q       <= 1'b0;
                last_owner_q <= owner_q;
            end else if (state_q != ARB_IDLE && owner_q == OWN_IF && if_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ysyx_22040632_mem_arbiter.md
# ysyx_22040632_mem_arbiter

Two-requester memory arbiter that shares the single core-side memory bus between the IFU instruction fetch and the MEM-stage load/store unit. It sits between the IF/MEM stages and the bus bridge. Each transaction is captured into a request register, driven downstream with a valid/ready handshake, and its response is routed back to the owning requester. Only one transaction is outstanding at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IFU fetch request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  redirect/fence_i: cancel any pending IFU response
- if_resp_valid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  DATA_W  fetch data
- if_resp_err  out  1  bus error with if_resp_valid
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  ADDR_W  load/store address
- ls_wen  in  1  1 = store
- ls_wdata  in  DATA_W  store data
- ls_wstrb  in  DATA_W/8  store byte strobes
- ls_size  in  2  log2 bytes (0..3)
- ls_resp_valid  out  1  load data / store ack, 1-cycle pulse
- ls_rdata  out  DATA_W  load data
- ls_resp_err  out  1  bus error with ls_resp_valid
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_size  out  ADDR_W/1/DATA_W/DATA_W/8/2  captured request fields
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DATA_W  response data
- mem_resp_err  in  1  response error

## Operation
- FSM states: ARB_IDLE, ARB_REQ, ARB_RESP. Reset: ARB_IDLE, owner=OWN_IF, last_owner=OWN_IF, drop=0, all request registers 0.
- ARB_IDLE: if any eligible request, pick a winner, assert its req_ready (combinational, IDLE only), capture fields, set owner, -> ARB_REQ. IFU request with if_flush=1 that cycle is ineligible.
- IFU capture: mem_wen=0, mem_wstrb=0, mem_size=2 (4 B), mem_wdata=0.
- ARB_REQ: mem_req_valid=1, fields stable; on mem_req_ready -> ARB_RESP.
- ARB_RESP: wait mem_resp_valid; route mem_rdata/mem_resp_err combinationally to owner, pulse owner resp_valid unless drop=1; -> ARB_IDLE, clear drop, last_owner<=owner.
- mem_resp_valid outside ARB_RESP: ignored.
- if_flush while owner=OWN_IF in ARB_REQ or ARB_RESP: drop<=1; transaction still completes downstream, response absorbed, if_resp_valid stays 0. if_flush with owner=OWN_LS: no effect.
- Non-owner resp_valid always 0; rdata outputs carry mem_rdata regardless (qualified by valid).

## Timing
- Accept at cycle N (req_ready=1); mem_req_valid from N+1; with mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid at N+2; next grant earliest N+3.
- Requesters hold valid and fields until req_ready; fields not needed after acceptance.
- Async rst_n mid-transaction: immediate ARB_IDLE, outstanding transaction dropped; bus bridge shares rst_n.

## Configuration
- YSYX_22040632_ARB_RR_EN defined: both valid in ARB_IDLE -> grant the requester not equal to last_owner (round robin).
- Undefined: fixed priority, LSU always wins over IFU; last_owner kept but unused for arbitration.

## Structure
- ysyx_22040632_pkg: arb_state_t {ARB_IDLE, ARB_REQ, ARB_RESP}, arb_owner_t {OWN_IF, OWN_LS}, IFU fetch size constant (2).
- Sub-module ysyx_22040632_arb_pick: combinational winner selection from valids, flush and last_owner, holding the macro-dependent logic.

## Test plan
- IFU only, if_addr=0x80000000, mem_req_ready=1 immediately, resp at N+2 rdata=0x0000_0013_0000_0093 -> if_resp_valid at N+2 with that data; mem_wen=0, mem_size=2.
- Both valid in IDLE, last_owner=OWN_LS: without macro LSU granted; with YSYX_22040632_ARB_RR_EN IFU granted, LSU granted on next IDLE.
- LSU store ls_addr=0x80001000, wdata=0xDEADBEEF, wstrb=0x0F, mem_req_ready delayed 3 cycles -> mem_* fields stable all 3 cycles, ls_resp_valid once on response.
- IFU owner, if_flush in ARB_RESP, response 2 cycles later -> if_resp_valid stays 0, FSM returns ARB_IDLE, pending LSU then granted.
- mem_resp_err=1 on LSU load -> ls_resp_valid=1 and ls_resp_err=1 same cycle; if_resp_valid=0.
- rst_n low during ARB_REQ -> mem_req_valid=0 immediately, state ARB_IDLE, new IFU request granted after release.
